// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the i2c_slave target.
//   - i2c_state_t   : protocol state of the target FSM
//   - I2C_READ/WRITE: value of the r_w bit that follows the 7-bit address
//   - DEFAULT_SLAVE_ADDR : address answered to when not overridden
//   - addr_match()  : compares a received {addr, r_w} frame with an address
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR       = 3'd1,
        ADDR_ACK   = 3'd2,
        WRITE_DATA = 3'd3,
        WRITE_ACK  = 3'd4,
        READ_DATA  = 3'd5,
        READ_ACK   = 3'd6,
        WAIT_STOP  = 3'd7
    } i2c_state_t;

    localparam logic       I2C_READ           = 1'b1;
    localparam logic       I2C_WRITE          = 1'b0;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

    // Upper seven bits of the first byte carry the address, bit 0 is r_w.
    function automatic logic addr_match(input logic [7:0] frame, input logic [6:0] addr);
        return (frame[7:1] == addr);
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_if
// Groups the bus pins and the host-side byte interface of i2c_slave.
//   scl, sda           : bus levels as seen at the pad
//   slave_sda_en       : 1 = pull sda to ssda_buffer, 0 = release
//   ssda_buffer        : value driven when slave_sda_en = 1
//   tx_data / tx_req   : byte returned on a read, latched on the tx_req pulse
//   rx_data / rx_valid : byte received on a write, rx_valid pulses on update
//   busy, done, nack_seen : transaction status
// Modports: slave (the target), master (bus/host side driving it).
// ---------------------------------------------------------------------------
interface i2c_slave_if;

    logic       scl;
    logic       sda;
    logic       slave_sda_en;
    logic       ssda_buffer;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       nack_seen;

    modport slave (
        input  scl, sda, tx_data,
        output slave_sda_en, ssda_buffer, tx_req, rx_data, rx_valid,
               busy, done, nack_seen
    );

    modport master (
        output scl, sda, tx_data,
        input  slave_sda_en, ssda_buffer, tx_req, rx_data, rx_valid,
               busy, done, nack_seen
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings scl/sda into the clk domain and derives bus events.
//   clk, rst    : system clock, asynchronous active-high reset
//   scl, sda    : raw pad levels
//   scl_rise    : scl went 0->1
//   scl_fall    : scl went 1->0
//   start_det   : sda fell while scl stayed high
//   stop_det    : sda rose while scl stayed high
//   sda_s       : synchronized (and optionally filtered) sda level
// Build option I2C_SLAVE_GLITCH_FILTER_EN: adds a 3-sample stability filter
// on both lines (2 clk extra latency, pulses of 2 clk or less rejected).
// Event flags are combinational from registered levels; the consumer
// registers them, giving SYNC_STAGES+1 clk from pad to action.
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_lvl_s;
    logic                   sda_lvl_s;
    logic                   scl_prev_r;
    logic                   sda_prev_r;

    // Multi-flop synchronizer; idles high like the released bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist_r;
    logic [1:0] sda_hist_r;
    logic       scl_filt_r;
    logic       sda_filt_r;

    // Accept a new level only once three consecutive samples agree.
    always_comb begin
        scl_lvl_s = scl_filt_r;
        sda_lvl_s = sda_filt_r;
        if ((scl_sync_r[SYNC_STAGES-1] == scl_hist_r[0]) && (scl_hist_r[0] == scl_hist_r[1])) begin
            scl_lvl_s = scl_sync_r[SYNC_STAGES-1];
        end else begin
            scl_lvl_s = scl_filt_r;
        end
        if ((sda_sync_r[SYNC_STAGES-1] == sda_hist_r[0]) && (sda_hist_r[0] == sda_hist_r[1])) begin
            sda_lvl_s = sda_sync_r[SYNC_STAGES-1];
        end else begin
            sda_lvl_s = sda_filt_r;
        end
    end

    // Sample history and held filter level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist_r <= 2'b11;
            sda_hist_r <= 2'b11;
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
        end else begin
            scl_hist_r <= {scl_hist_r[0], scl_sync_r[SYNC_STAGES-1]};
            sda_hist_r <= {sda_hist_r[0], sda_sync_r[SYNC_STAGES-1]};
            scl_filt_r <= scl_lvl_s;
            sda_filt_r <= sda_lvl_s;
        end
    end
`else
    assign scl_lvl_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_lvl_s = sda_sync_r[SYNC_STAGES-1];
`endif

    // Previous level, used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_lvl_s;
            sda_prev_r <= sda_lvl_s;
        end
    end

    assign scl_rise  = scl_lvl_s & ~scl_prev_r;
    assign scl_fall  = ~scl_lvl_s & scl_prev_r;
    // scl must be high in both samples so a simultaneous scl/sda move is no event.
    assign start_det = scl_lvl_s & scl_prev_r & sda_prev_r & ~sda_lvl_s;
    assign stop_det  = scl_lvl_s & scl_prev_r & ~sda_prev_r & sda_lvl_s;
    assign sda_s     = sda_lvl_s;

endmodule

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave
// Single-address I2C target handling one data byte per transaction.
//   clk  : 125 MHz system clock
//   rst  : asynchronous, active-high reset (releases sda immediately)
//   bus  : i2c_slave_if.slave -- scl/sda pad levels, open-drain enable/value,
//          tx_data/tx_req read byte, rx_data/rx_valid write byte,
//          busy/done/nack_seen status.
// Parameters: SLAVE_ADDR (7-bit address), SYNC_STAGES (>= 2).
// Build option I2C_SLAVE_GLITCH_FILTER_EN enables the scl/sda glitch filter
// inside i2c_bus_sync.
// All outputs are registered; sda only ever changes on an scl fall.
// ---------------------------------------------------------------------------
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    i2c_slave_if.slave bus
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_state_t state_r,    state_next_s;
    logic [3:0] bit_cnt_r,  bit_cnt_next_s;
    logic [7:0] shreg_r,    shreg_next_s;
    logic [7:0] tx_shreg_r, tx_shreg_next_s;
    logic       rw_r,       rw_next_s;
    logic       sda_en_r,   sda_en_next_s;
    logic       sda_out_r,  sda_out_next_s;
    logic [7:0] rx_data_r,  rx_data_next_s;
    logic       rx_valid_r, rx_valid_next_s;
    logic       tx_req_r,   tx_req_next_s;
    logic       busy_r,     busy_next_s;
    logic       done_r,     done_next_s;
    logic       nack_r,     nack_next_s;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (bus.scl),
        .sda       (bus.sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    // Next-state and output logic; START/STOP override any bit handling.
    always_comb begin
        state_next_s    = state_r;
        bit_cnt_next_s  = bit_cnt_r;
        shreg_next_s    = shreg_r;
        tx_shreg_next_s = tx_shreg_r;
        rw_next_s       = rw_r;
        sda_en_next_s   = sda_en_r;
        sda_out_next_s  = sda_out_r;
        rx_data_next_s  = rx_data_r;
        rx_valid_next_s = 1'b0;
        tx_req_next_s   = 1'b0;
        busy_next_s     = busy_r;
        done_next_s     = 1'b0;
        nack_next_s     = nack_r;

        if (stop_det) begin
            state_next_s   = IDLE;
            bit_cnt_next_s = 4'd0;
            sda_en_next_s  = 1'b0;
            sda_out_next_s = 1'b0;
            busy_next_s    = 1'b0;
            done_next_s    = busy_r;
        end else if (start_det) begin
            state_next_s   = ADDR;
            bit_cnt_next_s = 4'd0;
            sda_en_next_s  = 1'b0;
            sda_out_next_s = 1'b0;
            nack_next_s    = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    sda_en_next_s = 1'b0;
                end

                ADDR: begin
                    if (scl_rise && (bit_cnt_r != 4'd8)) begin
                        shreg_next_s   = {shreg_r[6:0], sda_s};
                        bit_cnt_next_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall && (bit_cnt_r == 4'd8)) begin
                        bit_cnt_next_s = 4'd0;
                        if (addr_match(shreg_r, SLAVE_ADDR)) begin
                            state_next_s   = ADDR_ACK;
                            sda_en_next_s  = 1'b1;
                            sda_out_next_s = 1'b0;
                            busy_next_s    = 1'b1;
                            rw_next_s      = shreg_r[0];
                            if (shreg_r[0] == I2C_READ) begin
                                tx_shreg_next_s = bus.tx_data;
                                tx_req_next_s   = 1'b1;
                            end else begin
                                tx_shreg_next_s = tx_shreg_r;
                            end
                        end else begin
                            state_next_s = WAIT_STOP;
                        end
                    end else begin
                        state_next_s = ADDR;
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_r == I2C_READ) begin
                            // First data bit goes out on the same fall that ends the ACK.
                            state_next_s    = READ_DATA;
                            sda_en_next_s   = 1'b1;
                            sda_out_next_s  = tx_shreg_r[7];
                            tx_shreg_next_s = {tx_shreg_r[6:0], 1'b0};
                            bit_cnt_next_s  = 4'd1;
                        end else begin
                            state_next_s   = WRITE_DATA;
                            sda_en_next_s  = 1'b0;
                            sda_out_next_s = 1'b0;
                            bit_cnt_next_s = 4'd0;
                        end
                    end else begin
                        state_next_s = ADDR_ACK;
                    end
                end

                WRITE_DATA: begin
                    if (scl_rise && (bit_cnt_r != 4'd8)) begin
                        shreg_next_s   = {shreg_r[6:0], sda_s};
                        bit_cnt_next_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall && (bit_cnt_r == 4'd8)) begin
                        state_next_s    = WRITE_ACK;
                        bit_cnt_next_s  = 4'd0;
                        sda_en_next_s   = 1'b1;
                        sda_out_next_s  = 1'b0;
                        rx_data_next_s  = shreg_r;
                        rx_valid_next_s = 1'b1;
                    end else begin
                        state_next_s = WRITE_DATA;
                    end
                end

                WRITE_ACK: begin
                    if (scl_fall) begin
                        state_next_s   = WAIT_STOP;
                        sda_en_next_s  = 1'b0;
                        sda_out_next_s = 1'b0;
                    end else begin
                        state_next_s = WRITE_ACK;
                    end
                end

                READ_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_r == 4'd8) begin
                            state_next_s   = READ_ACK;
                            bit_cnt_next_s = 4'd0;
                            sda_en_next_s  = 1'b0;
                            sda_out_next_s = 1'b0;
                        end else begin
                            sda_out_next_s  = tx_shreg_r[7];
                            tx_shreg_next_s = {tx_shreg_r[6:0], 1'b0};
                            bit_cnt_next_s  = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_next_s = READ_DATA;
                    end
                end

                READ_ACK: begin
                    if (scl_rise) begin
                        state_next_s = WAIT_STOP;
                        if (sda_s) begin
                            nack_next_s = 1'b1;
                        end else begin
                            nack_next_s = nack_r;
                        end
                    end else begin
                        state_next_s = READ_ACK;
                    end
                end

                WAIT_STOP: begin
                    sda_en_next_s = 1'b0;
                end

                default: begin
                    state_next_s  = IDLE;
                    sda_en_next_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 4'd0;
            shreg_r    <= 8'd0;
            tx_shreg_r <= 8'd0;
            rw_r       <= 1'b0;
            sda_en_r   <= 1'b0;
            sda_out_r  <= 1'b0;
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            nack_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shreg_r    <= shreg_next_s;
            tx_shreg_r <= tx_shreg_next_s;
            rw_r       <= rw_next_s;
            sda_en_r   <= sda_en_next_s;
            sda_out_r  <= sda_out_next_s;
            rx_data_r  <= rx_data_next_s;
            rx_valid_r <= rx_valid_next_s;
            tx_req_r   <= tx_req_next_s;
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
            nack_r     <= nack_next_s;
        end
    end

    assign bus.slave_sda_en = sda_en_r;
    assign bus.ssda_buffer  = sda_out_r;
    assign bus.tx_req       = tx_req_r;
    assign bus.rx_data      = rx_data_r;
    assign bus.rx_valid     = rx_valid_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.nack_seen    = nack_r;

endmodule

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave
// Directed bench for i2c_slave: a bit-banged bus master with open-drain
// wired-AND on sda, pulse counters on the status strobes, and one checking
// task through which every comparison goes.
// ---------------------------------------------------------------------------
module tb_i2c_slave;

    localparam int Q = 10;  // clk cycles per quarter scl period

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam logic GLITCH_ACK_EXP = 1'b0;
`else
    localparam logic GLITCH_ACK_EXP = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    int rxv_cnt  = 0;
    int txr_cnt  = 0;
    int done_cnt = 0;
    int en_cnt   = 0;

    i2c_slave_if bus ();

    assign bus.scl = m_scl;
    assign bus.sda = m_sda & (bus.slave_sda_en ? bus.ssda_buffer : 1'b1);

    i2c_slave #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #4 clk = ~clk;

    // Strobe counters; tests look at deltas.
    always @(posedge clk) begin
        if (bus.rx_valid)     rxv_cnt  <= rxv_cnt + 1;
        if (bus.tx_req)       txr_cnt  <= txr_cnt + 1;
        if (bus.done)         done_cnt <= done_cnt + 1;
        if (bus.slave_sda_en) en_cnt   <= en_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        b = bus.sda;  wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    initial begin
        logic       ack;
        logic       ack2;
        logic [7:0] d;
        int         c0;
        int         c1;
        int         c2;
        int         c3;

        bus.tx_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_sda_en",   {31'd0, bus.slave_sda_en}, 32'd0);
        check_val("rst_busy",     {31'd0, bus.busy},         32'd0);
        check_val("rst_rx_data",  {24'd0, bus.rx_data},      32'd0);
        check_val("rst_rx_valid", {31'd0, bus.rx_valid},     32'd0);
        check_val("rst_done",     {31'd0, bus.done},         32'd0);
        check_val("rst_nack",     {31'd0, bus.nack_seen},    32'd0);
        rst = 1'b0;
        wait_q();

        // Write 0xA5 to 0x50
        c0 = rxv_cnt; c1 = done_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check_val("wr_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hA5, ack);
        check_val("wr_data_ack", {31'd0, ack}, 32'd0);
        check_val("wr_rx_data",  {24'd0, bus.rx_data}, 32'hA5);
        check_val("wr_rxv_cnt",  rxv_cnt - c0, 32'd1);
        check_val("wr_busy_hi",  {31'd0, bus.busy}, 32'd1);
        bus_stop();
        wait_q();
        check_val("wr_done_cnt", done_cnt - c1, 32'd1);
        check_val("wr_busy_lo",  {31'd0, bus.busy}, 32'd0);

        // Read 0x3C from 0x50, master NACKs
        bus.tx_data = 8'h3C;
        c0 = txr_cnt; c1 = done_cnt;
        bus_start();
        write_byte(8'hA1, ack);
        check_val("rd_addr_ack", {31'd0, ack}, 32'd0);
        check_val("rd_txreq_cnt", txr_cnt - c0, 32'd1);
        read_byte(d, 1'b1);
        check_val("rd_data",     {24'd0, d}, 32'h3C);
        check_val("rd_nack",     {31'd0, bus.nack_seen}, 32'd1);
        bus_stop();
        wait_q();
        check_val("rd_done_cnt", done_cnt - c1, 32'd1);
        check_val("rd_nack_sticky", {31'd0, bus.nack_seen}, 32'd1);

        // Write to foreign address 0x22
        c0 = rxv_cnt; c1 = done_cnt; c2 = en_cnt;
        bus_start();
        write_byte(8'h44, ack);
        check_val("fa_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h5A, ack);
        bus_stop();
        wait_q();
        check_val("fa_en_cnt",   en_cnt - c2,   32'd0);
        check_val("fa_rxv_cnt",  rxv_cnt - c0,  32'd0);
        check_val("fa_done_cnt", done_cnt - c1, 32'd0);

        // Repeated START in the middle of a write byte, then read
        c0 = rxv_cnt;
        bus_start();
        check_val("rs_nack_cleared", {31'd0, bus.nack_seen}, 32'd0);
        write_byte(8'hA0, ack);
        check_val("rs_wr_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        bus.tx_data = 8'h96;
        bus_start();
        write_byte(8'hA1, ack);
        check_val("rs_rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(d, 1'b1);
        check_val("rs_rd_data", {24'd0, d}, 32'h96);
        check_val("rs_rxv_cnt", rxv_cnt - c0, 32'd0);
        check_val("rs_nack",    {31'd0, bus.nack_seen}, 32'd1);
        bus_stop();
        wait_q();

        // Reset in the middle of a read byte, then a normal write
        bus.tx_data = 8'hF0;
        bus_start();
        write_byte(8'hA1, ack);
        for (int i = 0; i < 3; i++) read_bit(ack2);
        check_val("mr_en_before", {31'd0, bus.slave_sda_en}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mr_sda_en", {31'd0, bus.slave_sda_en}, 32'd0);
        check_val("mr_busy",   {31'd0, bus.busy},         32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_q();
        bus_stop();
        wait_q();
        c3 = rxv_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check_val("mr_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack);
        check_val("mr_data_ack", {31'd0, ack}, 32'd0);
        check_val("mr_rx_data",  {24'd0, bus.rx_data}, 32'h5A);
        check_val("mr_rxv_cnt",  rxv_cnt - c3, 32'd1);
        bus_stop();
        wait_q();

        // One-clk scl glitch during the address phase
        bus_start();
        m_scl = 1'b1;
        @(negedge clk);
        m_scl = 1'b0;
        wait_q();
        write_byte(8'hA0, ack);
        check_val("gl_addr_ack", {31'd0, ack}, {31'd0, GLITCH_ACK_EXP});
        bus_stop();
        wait_q();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
